// File: rtl/buzzer_scheduler.sv
// Arbitrates the piezo buzzer between alarm, hourly chime and key-press feedback,
// producing each source's on/off cadence from the 1 ms tick plus alarm snooze/timeout.
module buzzer_scheduler #(
    parameter int TONE_DIV         = 2500,
    parameter int BEEP_MS          = 50,
    parameter int CHIME_ON_MS      = 150,
    parameter int CHIME_GAP_MS     = 150,
    parameter int CHIME_PULSES     = 2,
    parameter int ALARM_ON_MS      = 500,
    parameter int ALARM_OFF_MS     = 500,
    parameter int ALARM_TIMEOUT_MS = 60000,
    parameter int SNOOZE_MS        = 300000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic       key_beep_pulse,
    input  logic       alarm_off_pulse,
    input  logic       snooze_pulse,
    output logic       buzzer,
    output logic [1:0] active_src,
    output logic       snoozing,
    output logic       alarm_clear
);

    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [TONE_W-1:0] TONE_LAST    = TONE_W'(TONE_DIV - 1);
    localparam logic [19:0]       BEEP_LAST    = 20'(BEEP_MS - 1);
    localparam logic [19:0]       CH_ON_LAST   = 20'(CHIME_ON_MS - 1);
    localparam logic [19:0]       CH_GAP_LAST  = 20'(CHIME_GAP_MS - 1);
    localparam logic [19:0]       PULSE_LAST   = 20'(CHIME_PULSES);
    localparam logic [19:0]       AL_ON_LAST   = 20'(ALARM_ON_MS - 1);
    localparam logic [19:0]       AL_OFF_LAST  = 20'(ALARM_OFF_MS - 1);
    localparam logic [19:0]       TIMEOUT_LAST = 20'(ALARM_TIMEOUT_MS - 1);
    localparam logic [19:0]       SNOOZE_LAST  = 20'(SNOOZE_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        CH_ON,
        CH_GAP,
        AL_ON,
        AL_OFF,
        SNOOZE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [19:0]         dur_cnt;
    logic [19:0]         to_cnt;
    logic [19:0]         pulse_cnt;
    logic [19:0]         pulse_nxt;
    logic                chime_pend;
    logic                pend_nxt;
    logic                chime_q;
    logic                armed;
    logic                tone;
    logic                tone_nxt;
    logic                tone_wrap;
    logic [TONE_W-1:0]   tone_cnt;
    logic                restart;
    logic                to_clear;
    logic                clear_evt;
    logic                chime_edge;
    logic                alarm_go;

    function automatic logic expired(input logic tick, input logic [19:0] cnt,
                                     input logic [19:0] last);
        return tick && (cnt == last);
    endfunction

    function automatic logic gate_on(input state_t s);
        return (s == KEY) || (s == CH_ON) || (s == AL_ON);
    endfunction

    function automatic logic [1:0] src_of(input state_t s);
        case (s)
            KEY:                   return 2'd1;
            CH_ON, CH_GAP:         return 2'd2;
            AL_ON, AL_OFF, SNOOZE: return 2'd3;
            default:               return 2'd0;
        endcase
    endfunction

    assign chime_edge = chime_req & ~chime_q;
    assign alarm_go   = alarm_req & armed;
    assign tone_wrap  = (tone_cnt == TONE_LAST);
    assign tone_nxt   = tone ^ tone_wrap;

    always_comb begin
        state_nxt = state;
        pulse_nxt = pulse_cnt;
        pend_nxt  = chime_pend;
        restart   = 1'b0;
        to_clear  = 1'b0;
        clear_evt = 1'b0;
        case (state)
            IDLE: begin
                if (alarm_go) begin
                    state_nxt = AL_ON;
                    to_clear  = 1'b1;
                end else if (chime_edge) begin
                    state_nxt = CH_ON;
                    pulse_nxt = 20'd1;
                end else if (key_beep_pulse) begin
                    state_nxt = KEY;
                end
            end
            KEY: begin
                if (alarm_go) begin
                    state_nxt = AL_ON;
                    to_clear  = 1'b1;
                    pend_nxt  = 1'b0;
                end else if (expired(tick_ms, dur_cnt, BEEP_LAST)) begin
                    pend_nxt = 1'b0;
                    if (chime_pend || chime_edge) begin
                        state_nxt = CH_ON;
                        pulse_nxt = 20'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (chime_edge) begin
                    pend_nxt = 1'b1;
                end
            end
            CH_ON: begin
                if (alarm_go) begin
                    state_nxt = AL_ON;
                    to_clear  = 1'b1;
                end else if (expired(tick_ms, dur_cnt, CH_ON_LAST)) begin
                    state_nxt = CH_GAP;
                end
            end
            CH_GAP: begin
                if (alarm_go) begin
                    state_nxt = AL_ON;
                    to_clear  = 1'b1;
                end else if (expired(tick_ms, dur_cnt, CH_GAP_LAST)) begin
                    if (pulse_cnt >= PULSE_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CH_ON;
                        pulse_nxt = pulse_cnt + 20'd1;
                    end
                end
            end
            AL_ON, AL_OFF: begin
                // dismiss and timeout both hand the clear back upstream
                if (alarm_off_pulse || expired(tick_ms, to_cnt, TIMEOUT_LAST)) begin
                    state_nxt = IDLE;
                    clear_evt = 1'b1;
                end else if (!alarm_req) begin
                    state_nxt = IDLE;
                end else if (snooze_pulse) begin
                    state_nxt = SNOOZE;
                end else if (state == AL_ON && expired(tick_ms, dur_cnt, AL_ON_LAST)) begin
                    state_nxt = AL_OFF;
                end else if (state == AL_OFF && expired(tick_ms, dur_cnt, AL_OFF_LAST)) begin
                    state_nxt = AL_ON;
                end
            end
            SNOOZE: begin
                if (alarm_off_pulse) begin
                    state_nxt = IDLE;
                    clear_evt = 1'b1;
                end else if (!alarm_req) begin
                    state_nxt = IDLE;
                end else if (snooze_pulse) begin
                    restart = 1'b1;
                end else if (expired(tick_ms, dur_cnt, SNOOZE_LAST)) begin
                    state_nxt = AL_ON;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dur_cnt     <= '0;
            to_cnt      <= '0;
            pulse_cnt   <= '0;
            chime_pend  <= 1'b0;
            chime_q     <= 1'b0;
            armed       <= 1'b1;
            tone        <= 1'b0;
            tone_cnt    <= '0;
            buzzer      <= 1'b0;
            active_src  <= 2'd0;
            snoozing    <= 1'b0;
            alarm_clear <= 1'b0;
        end else begin
            state      <= state_nxt;
            pulse_cnt  <= pulse_nxt;
            chime_pend <= pend_nxt;
            chime_q    <= chime_req;
            tone       <= tone_nxt;
            tone_cnt   <= tone_wrap ? '0 : tone_cnt + TONE_W'(1);

            if (restart || (state_nxt != state)) begin
                dur_cnt <= '0;
            end else if (tick_ms) begin
                dur_cnt <= dur_cnt + 20'd1;
            end

            // ring time accumulates across snoozes; only a fresh alarm restarts it
            if (to_clear) begin
                to_cnt <= '0;
            end else if (tick_ms && (state == AL_ON || state == AL_OFF)) begin
                to_cnt <= to_cnt + 20'd1;
            end

            if (clear_evt) begin
                armed <= 1'b0;
            end else if (!alarm_req) begin
                armed <= 1'b1;
            end

            buzzer      <= tone_nxt & gate_on(state_nxt);
            active_src  <= src_of(state_nxt);
            snoozing    <= (state_nxt == SNOOZE);
            alarm_clear <= clear_evt;
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: directed scenarios plus random traffic, each cycle
// compared against a countdown-based behavioural model of the scheduling rules.
module tb_buzzer_scheduler;

    localparam int TONE_DIV         = 2;
    localparam int BEEP_MS          = 3;
    localparam int CHIME_ON_MS      = 2;
    localparam int CHIME_GAP_MS     = 2;
    localparam int CHIME_PULSES     = 2;
    localparam int ALARM_ON_MS      = 2;
    localparam int ALARM_OFF_MS     = 2;
    localparam int ALARM_TIMEOUT_MS = 10;
    localparam int SNOOZE_MS        = 5;
    localparam int TICK_PERIOD      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_ms;
    logic       alarm_req;
    logic       chime_req;
    logic       key_beep_pulse;
    logic       alarm_off_pulse;
    logic       snooze_pulse;
    logic       buzzer;
    logic [1:0] active_src;
    logic       snoozing;
    logic       alarm_clear;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    buzzer_scheduler #(
        .TONE_DIV(TONE_DIV), .BEEP_MS(BEEP_MS), .CHIME_ON_MS(CHIME_ON_MS),
        .CHIME_GAP_MS(CHIME_GAP_MS), .CHIME_PULSES(CHIME_PULSES),
        .ALARM_ON_MS(ALARM_ON_MS), .ALARM_OFF_MS(ALARM_OFF_MS),
        .ALARM_TIMEOUT_MS(ALARM_TIMEOUT_MS), .SNOOZE_MS(SNOOZE_MS)
    ) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .alarm_req(alarm_req),
        .chime_req(chime_req), .key_beep_pulse(key_beep_pulse),
        .alarm_off_pulse(alarm_off_pulse), .snooze_pulse(snooze_pulse),
        .buzzer(buzzer), .active_src(active_src), .snoozing(snoozing),
        .alarm_clear(alarm_clear)
    );

    // behavioural model: who owns the buzzer and how many ms remain in the phase
    typedef enum int {R_NONE, R_KEY, R_CHIME, R_ALARM, R_SNOOZE} owner_t;
    owner_t m_owner;
    int     m_sounding, m_left, m_ring_left, m_pulse, m_pend, m_armed;
    int     m_prev_chime, m_edges, m_clear;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = R_NONE; m_sounding = 0; m_left = 0; m_ring_left = 0; m_pulse = 0;
        m_pend = 0; m_armed = 1; m_prev_chime = 0; m_edges = 0; m_clear = 0;
    endtask

    task automatic start_alarm();
        m_owner = R_ALARM; m_sounding = 1; m_left = ALARM_ON_MS;
        m_ring_left = ALARM_TIMEOUT_MS; m_pend = 0;
    endtask

    task automatic start_chime();
        m_owner = R_CHIME; m_sounding = 1; m_left = CHIME_ON_MS; m_pulse = 1;
    endtask

    task automatic dismiss();
        m_owner = R_NONE; m_clear = 1; m_armed = 0;
    endtask

    task automatic model_step();
        int edge_c, go, tk, timed_out;
        edge_c  = (chime_req && !m_prev_chime) ? 1 : 0;
        go      = (alarm_req && m_armed != 0) ? 1 : 0;
        tk      = tick_ms ? 1 : 0;
        m_clear = 0;
        case (m_owner)
            R_NONE: begin
                if (go != 0) start_alarm();
                else if (edge_c != 0) start_chime();
                else if (key_beep_pulse) begin m_owner = R_KEY; m_left = BEEP_MS; end
            end
            R_KEY: begin
                if (go != 0) start_alarm();
                else begin
                    if (tk != 0) m_left--;
                    if (m_left == 0) begin
                        if (m_pend != 0 || edge_c != 0) start_chime();
                        else m_owner = R_NONE;
                        m_pend = 0;
                    end else if (edge_c != 0) m_pend = 1;
                end
            end
            R_CHIME: begin
                if (go != 0) start_alarm();
                else if (tk != 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_sounding != 0) begin m_sounding = 0; m_left = CHIME_GAP_MS; end
                        else if (m_pulse == CHIME_PULSES) m_owner = R_NONE;
                        else begin m_sounding = 1; m_pulse++; m_left = CHIME_ON_MS; end
                    end
                end
            end
            R_ALARM: begin
                timed_out = (tk != 0 && m_ring_left == 1) ? 1 : 0;
                if (tk != 0) m_ring_left--;
                if (alarm_off_pulse || timed_out != 0) dismiss();
                else if (!alarm_req) m_owner = R_NONE;
                else if (snooze_pulse) begin m_owner = R_SNOOZE; m_left = SNOOZE_MS; end
                else if (tk != 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_sounding = (m_sounding != 0) ? 0 : 1;
                        m_left = (m_sounding != 0) ? ALARM_ON_MS : ALARM_OFF_MS;
                    end
                end
            end
            R_SNOOZE: begin
                if (alarm_off_pulse) dismiss();
                else if (!alarm_req) m_owner = R_NONE;
                else if (snooze_pulse) m_left = SNOOZE_MS;
                else if (tk != 0) begin
                    m_left--;
                    if (m_left == 0) begin m_owner = R_ALARM; m_sounding = 1; m_left = ALARM_ON_MS; end
                end
            end
            default: m_owner = R_NONE;
        endcase
        if (m_clear == 0 && !alarm_req) m_armed = 1;
        m_prev_chime = chime_req ? 1 : 0;
    endtask

    task automatic compare_outputs();
        int src, gate, tone;
        case (m_owner)
            R_KEY:    begin src = 1; gate = 1; end
            R_CHIME:  begin src = 2; gate = m_sounding; end
            R_ALARM:  begin src = 3; gate = m_sounding; end
            R_SNOOZE: begin src = 3; gate = 0; end
            default:  begin src = 0; gate = 0; end
        endcase
        tone = (m_edges / TONE_DIV) % 2;
        check("active_src", int'(active_src), src);
        check("buzzer", int'(buzzer), (tone == 1 && gate != 0) ? 1 : 0);
        check("snoozing", int'(snoozing), (m_owner == R_SNOOZE) ? 1 : 0);
        check("alarm_clear", int'(alarm_clear), m_clear);
    endtask

    task automatic step();
        tick_ms = ((cyc % TICK_PERIOD) == TICK_PERIOD - 1);
        @(posedge clk);
        m_edges++;
        model_step();
        @(negedge clk);
        compare_outputs();
        cyc++;
        key_beep_pulse  = 1'b0;
        alarm_off_pulse = 1'b0;
        snooze_pulse    = 1'b0;
    endtask

    initial begin
        int nclr;
        rst = 1'b1; tick_ms = 1'b0; alarm_req = 1'b0; chime_req = 1'b0;
        key_beep_pulse = 1'b0; alarm_off_pulse = 1'b0; snooze_pulse = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_buzzer", int'(buzzer), 0);
        check("reset_src", int'(active_src), 0);
        check("reset_snoozing", int'(snoozing), 0);
        check("reset_clear", int'(alarm_clear), 0);
        rst = 1'b0;
        repeat (3) step();

        // key beep, with a second press mid-beep
        key_beep_pulse = 1'b1; step();
        check("key_src", int'(active_src), 1);
        repeat (10) step();
        key_beep_pulse = 1'b1; step();
        repeat (30) step();

        // chime edge during a key beep, then held high
        key_beep_pulse = 1'b1; step();
        repeat (4) step();
        chime_req = 1'b1;
        repeat (80) step();
        chime_req = 1'b0;
        repeat (5) step();

        // alarm preempts a running chime
        chime_req = 1'b1; repeat (10) step();
        alarm_req = 1'b1; step();
        check("preempt_src", int'(active_src), 3);
        repeat (5) step();
        alarm_req = 1'b0; repeat (40) step();
        chime_req = 1'b0; repeat (3) step();

        // unattended alarm times out once; re-entry needs a low-then-high request
        alarm_req = 1'b1; nclr = 0;
        for (int i = 0; i < 120; i++) begin step(); if (alarm_clear) nclr++; end
        check("timeout_clear_count", nclr, 1);
        alarm_req = 1'b0; step();
        alarm_req = 1'b1; repeat (3) step();
        check("reentry_src", int'(active_src), 3);
        alarm_off_pulse = 1'b1; step();
        alarm_req = 1'b0; step();

        // snooze after a few ring ticks, then timeout on remaining ring time
        alarm_req = 1'b1; repeat (26) step();
        snooze_pulse = 1'b1; step();
        check("snooze_flag", int'(snoozing), 1);
        nclr = 0;
        for (int i = 0; i < 200; i++) begin step(); if (alarm_clear) nclr++; end
        check("snooze_timeout_count", nclr, 1);
        alarm_req = 1'b0; step();

        // dismiss and snooze in the same cycle
        alarm_req = 1'b1; repeat (12) step();
        alarm_off_pulse = 1'b1; snooze_pulse = 1'b1; step();
        check("off_snooze_clear", int'(alarm_clear), 1);
        check("off_snooze_src", int'(active_src), 0);
        alarm_req = 1'b0; step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) alarm_req = ~alarm_req;
            if ($urandom_range(0, 19) == 0) chime_req = ~chime_req;
            key_beep_pulse  = ($urandom_range(0, 11) == 0);
            alarm_off_pulse = ($urandom_range(0, 199) == 0);
            snooze_pulse    = ($urandom_range(0, 29) == 0);
            step();
        end

        // asynchronous reset while the alarm is sounding
        alarm_req = 1'b0; chime_req = 1'b0; step();
        alarm_req = 1'b1; repeat (3) step();
        for (int i = 0; i < 40 && buzzer !== 1'b1; i++) step();
        check("buzz_before_rst", int'(buzzer), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_buzzer", int'(buzzer), 0);
        check("rst_async_src", int'(active_src), 0);
        alarm_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
